muldiv_hilo: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- Its hi/lo outputs drive the hi/lo operand inputs of the execute-stage ALU.
- Executes MULT/MULTU/MADD/MADDU/DIV/DIVU/MTHI/MTLO, using an iterative radix-2 datapath (shift-add multiply, restoring divide).
- The pipeline stalls on busy and reads HI/LO after done.

---
 rtl/muldiv_hilo.sv | 141 ++++++++++++++
 tb/tb_muldiv_hilo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// ============================================================================
// Module   : muldiv_hilo
// Purpose  : Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opb;
  // Multiply: {partial sum, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc;

  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] madd_sum;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // op[0] clear selects the signed variants.
  assign rs_neg = ~op[0] & rs[WIDTH-1];
  assign rt_neg = ~op[0] & rt[WIDTH-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign madd_sum = {hi, lo} + prod_fix;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      opb   <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == 3'b110) begin
              hi    <= rs;
              state <= S_DONE;
            end else if (op == 3'b111) begin
              lo    <= rs;
              state <= S_DONE;
            end else if (op[2] && (rt == '0)) begin
              hi    <= rs;
              lo    <= '1;
              state <= S_DONE;
            end else begin
              op_q  <= op;
              opb   <= rt_mag;
              acc   <= {{WIDTH{1'b0}}, rs_mag};
              neg_q <= rs_neg ^ rt_neg;
              neg_r <= rs_neg;
              cnt   <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else if (op_q[1]) begin
              {hi, lo} <= madd_sum;
            end else begin
              {hi, lo} <= prod_fix;
            end
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// ============================================================================
// Module   : tb_muldiv_hilo
// Purpose  : Directed plus random checks of muldiv_hilo against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        cancel = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] m_hilo = '0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of one instruction, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: return hl + 64'(sa * sb);
      3'd3: return hl + ua * ub;
      3'd4, 3'd5: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd4) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd6: return {a, hl[31:0]};
      default: return {hl[63:32], a};
    endcase
  endfunction

  // Issue one op and observe a fixed 40-cycle window after the start edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int stray_at, input int cancel_at,
                        input bit cancel_with_start);
    logic [63:0] exp;
    int          first_done, n_done, n_busy;
    bit          iter;
    first_done = 0;
    n_done     = 0;
    n_busy     = 0;
    iter = !((o[2:1] == 2'b11) || (o[2:1] == 2'b10 && b == 32'd0));
    exp  = model(o, a, b, m_hilo);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs     = a;
    rt     = b;
    cancel = cancel_with_start;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 40; k++) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
      start  = (k == stray_at);
      cancel = (k == cancel_at);
      op     = 3'($urandom);
      rs     = $urandom;
      rt     = $urandom;
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    cancel = 1'b0;
    if (iter && cancel_at > 0 && cancel_at <= 33) begin
      chk({tag, " done_count"}, 64'(n_done), 64'd0);
      chk({tag, " busy_cycles"}, 64'(n_busy), 64'(cancel_at));
    end else begin
      chk({tag, " done_count"}, 64'(n_done), 64'd1);
      chk({tag, " done_cycle"}, 64'(first_done), iter ? 64'd34 : 64'd1);
      chk({tag, " busy_cycles"}, 64'(n_busy), iter ? 64'd33 : 64'd0);
      m_hilo = exp;
    end
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, m_hilo[63:32]});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, m_hilo[31:0]});
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    chk("reset hilo", {hi, lo}, 64'd0);
    chk("reset busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult -2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0);
    chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op("mthi", 3'd6, 32'd0, 32'h5555_0000, 0, 0, 1'b0);
    run_op("mtlo", 3'd7, 32'd10, 32'd0, 0, 0, 1'b0);
    chk("mtlo const", {hi, lo}, 64'h0000_0000_0000_000A);
    run_op("maddu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("maddu const", {hi, lo}, 64'hFFFF_FFFE_0000_000B);
    run_op("madd", 3'd2, 32'hFFFF_FFFF, 32'd5, 0, 0, 1'b0);

    run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    chk("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    chk("divu const", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
    run_op("divu by0", 3'd5, 32'h0000_1234, 32'd0, 0, 0, 1'b0);
    chk("div0 const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div minint", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("minint const", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op("multu stray", 3'd1, 32'd5, 32'd7, 10, 0, 1'b0);
    chk("multu const", {hi, lo}, 64'd35);
    run_op("multu cancel", 3'd1, 32'd9, 32'd9, 0, 20, 1'b0);
    run_op("mult cancel_fix", 3'd0, 32'hFFFF_0001, 32'd77, 0, 33, 1'b0);
    run_op("start in done", 3'd0, 32'd123, 32'hFFFF_FF00, 34, 0, 1'b0);
    run_op("start+cancel", 3'd5, 32'd1000, 32'd7, 0, 36, 1'b1);

    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (n % 4 == 1) rb = 32'($urandom_range(1, 20));
      run_op($sformatf("rand%0d op%0d", n, ro), ro, ra, rb, 0, 0, 1'b0);
    end

    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    rs    = 32'h0000_0F0F;
    rt    = 32'h0000_0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst hilo", {hi, lo}, 64'd0);
    chk("async rst busy_done", {62'd0, busy, done}, 64'd0);
    m_hilo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("mult after rst", 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
